// File: rtl/t05_bit_packer_pkg.sv
// Shared types and constants for the Huffman bit packer slice.
// Includes the padding helpers used when the final partial byte is flushed.
package t05_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PACK  = 3'd1,
      FLUSH = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } packer_state_t;

   localparam logic [3:0] EN_TRANSLATE = 4'd5;
   localparam logic [7:0] EOF_CHAR     = 8'h1A;

   // Left-justify the bit_cnt valid bits of a partial byte, zero-filling the low end.
   function automatic logic [7:0] pad_byte(input logic [7:0] shreg, input logic [2:0] bit_cnt);
      logic [3:0] shamt;
      shamt    = 4'd8 - {1'b0, bit_cnt};
      pad_byte = shreg << shamt;
   endfunction

   function automatic logic [2:0] pad_count(input logic [2:0] bit_cnt);
      pad_count = 3'd0 - bit_cnt;
   endfunction

endpackage

// File: rtl/t05_byte_fifo.sv
// Synchronous byte FIFO with wrapping pointers, occupancy count and
// first-word fall-through head (reads as zero while empty).
module t05_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == CW'(0));
   assign count     = count_q;
   assign dout      = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;

   // Next-state for storage, pointers and occupancy; clear discards everything.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = AW'(0);
         rd_ptr_d = AW'(0);
         count_d  = CW'(0);
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         count_q  <= CW'(0);
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/t05_bit_packer.sv
// Packs the encoded bit stream MSB-first into bytes, buffers them toward the
// writer, zero-pads the last byte at end of file and reports pad/byte counts.
module t05_bit_packer
   import t05_pkg::*;
#(
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [3:0] ACTIVE_STATE = EN_TRANSLATE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  en_state,
   input  logic        bit_in,
   input  logic        bit_valid,
   input  logic        flush,
   output logic        stall,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic [31:0] total_bytes,
   output logic [2:0]  pad_bits,
   output logic        done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   packer_state_t state_q, state_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [31:0]   total_q, total_d;
   logic [2:0]    pad_q, pad_d;

   logic          active_s;
   logic          stall_s;
   logic          push_s;
   logic [7:0]    push_data_s;
   logic          pop_s;
   logic          clear_s;
   logic [7:0]    packed_s;
   logic [CW-1:0] fifo_count_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;

   assign active_s = (en_state == ACTIVE_STATE);
   assign stall_s  = ((state_q == PACK) || (state_q == FLUSH)) ? fifo_full_s : 1'b0;
   assign pop_s    = byte_ready & ~fifo_empty_s & (state_q != IDLE);
   assign packed_s = {shreg_q[6:0], bit_in};

   // Packer FSM: next state, shift register, counters and FIFO push/clear.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      total_d     = total_q;
      pad_d       = pad_q;
      push_s      = 1'b0;
      push_data_s = 8'h00;
      clear_s     = 1'b0;
      case (state_q)
         IDLE: begin
            clear_s   = 1'b1;
            shreg_d   = 8'h00;
            bit_cnt_d = 3'd0;
            total_d   = 32'd0;
            pad_d     = 3'd0;
            if (active_s) begin
               state_d = PACK;
            end else begin
               state_d = IDLE;
            end
         end
         PACK, FLUSH, DRAIN: begin
            if (!active_s) begin
               // Abort: drop buffered bytes and the partial byte in one step.
               clear_s   = 1'b1;
               state_d   = IDLE;
               shreg_d   = 8'h00;
               bit_cnt_d = 3'd0;
               total_d   = 32'd0;
               pad_d     = 3'd0;
            end else if (state_q == PACK) begin
               if (bit_valid && !stall_s) begin
                  shreg_d   = packed_s;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     push_s      = 1'b1;
                     push_data_s = packed_s;
                     total_d     = total_q + 32'd1;
                  end else begin
                     push_s = 1'b0;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q;
               end
               if (flush) begin
                  state_d = FLUSH;
               end else begin
                  state_d = PACK;
               end
            end else if (state_q == FLUSH) begin
               if (bit_cnt_q == 3'd0) begin
                  pad_d   = 3'd0;
                  state_d = DRAIN;
               end else if (!fifo_full_s) begin
                  push_s      = 1'b1;
                  push_data_s = pad_byte(shreg_q, bit_cnt_q);
                  pad_d       = pad_count(bit_cnt_q);
                  total_d     = total_q + 32'd1;
                  bit_cnt_d   = 3'd0;
                  state_d     = DRAIN;
               end else begin
                  state_d = FLUSH;
               end
            end else begin
               if (fifo_empty_s || ((fifo_count_s == CW'(1)) && pop_s)) begin
                  state_d = DONE;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DONE: begin
            if (!active_s) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            clear_s = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // Packer state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         shreg_q   <= 8'h00;
         bit_cnt_q <= 3'd0;
         total_q   <= 32'd0;
         pad_q     <= 3'd0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         total_q   <= total_d;
         pad_q     <= pad_d;
      end
   end

   t05_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_s),
      .push  (push_s),
      .din   (push_data_s),
      .pop   (pop_s),
      .dout  (byte_out),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign stall       = stall_s;
   assign byte_valid  = ~fifo_empty_s;
   assign total_bytes = total_q;
   assign pad_bits    = pad_q;
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_t05_bit_packer.sv
// Scoreboard bench for t05_bit_packer: a bit-level model queues expected bytes,
// a negedge monitor compares every popped byte against the queue head.
module tb_t05_bit_packer;
   import t05_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  en_state;
   logic        bit_in;
   logic        bit_valid;
   logic        flush;
   logic        stall;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] total_bytes;
   logic [2:0]  pad_bits;
   logic        done;

   always #5 clk = ~clk;

   t05_bit_packer #(
      .FIFO_DEPTH   (4),
      .ACTIVE_STATE (EN_TRANSLATE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en_state    (en_state),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .flush       (flush),
      .stall       (stall),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .total_bytes (total_bytes),
      .pad_bits    (pad_bits),
      .done        (done)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] m_acc;
   int         m_n;
   int         m_total;
   int         m_pad;
   int         stall_cycles;
   int         release_after;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every handshake seen before an edge is a pop at that edge.
   always @(negedge clk) begin
      if (rst && byte_valid && byte_ready) begin
         logic [31:0] e;
         e = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD_BEEF;
         check_val("byte_order", {24'h0, byte_out}, e);
      end
   end

   task automatic model_reset();
      m_acc = 8'h00; m_n = 0; m_total = 0; m_pad = 0;
   endtask

   task automatic model_bit(input logic b);
      m_acc = {m_acc[6:0], b};
      m_n++;
      if (m_n == 8) begin
         exp_q.push_back(m_acc);
         m_total++;
         m_n = 0;
      end
   endtask

   task automatic model_flush();
      if (m_n != 0) begin
         exp_q.push_back(m_acc << (8 - m_n));
         m_pad = 8 - m_n;
         m_total++;
      end else begin
         m_pad = 0;
      end
      m_n = 0;
   endtask

   task automatic send_bits(input logic [63:0] data, input int n, input bit flush_last);
      int guard;
      for (int i = n - 1; i >= 0; i--) begin
         guard     = 0;
         bit_in    = data[i];
         bit_valid = 1'b1;
         flush     = 1'b0;
         while (stall && guard < 200) begin
            if (guard == 0) check_val("stall_fifo_full", {31'h0, byte_valid}, 32'd1);
            stall_cycles++;
            guard++;
            if (release_after > 0 && stall_cycles >= release_after) byte_ready = 1'b1;
            step();
         end
         if (guard >= 200) check_val("stall_timeout", {31'h0, stall}, 32'd0);
         flush = flush_last && (i == 0);
         model_bit(data[i]);
         if (flush) model_flush();
         step();
      end
      bit_valid = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic do_flush();
      model_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic start_session();
      model_reset();
      en_state = EN_TRANSLATE;
      step();
   endtask

   task automatic finish_session(input string tag);
      int guard;
      guard = 0;
      while (!done && guard < 300) begin
         guard++;
         step();
      end
      check_val({tag, "_done"}, {31'h0, done}, 32'd1);
      check_val({tag, "_total"}, total_bytes, m_total);
      check_val({tag, "_pad"}, {29'h0, pad_bits}, m_pad);
      check_val({tag, "_sb_empty"}, exp_q.size(), 32'd0);
      en_state = 4'd0;
      step();
      step();
      check_val({tag, "_idle_done"}, {31'h0, done}, 32'd0);
      check_val({tag, "_idle_total"}, total_bytes, 32'd0);
   endtask

   initial begin
      rst = 1'b0; en_state = 4'd0; bit_in = 1'b0; bit_valid = 1'b0;
      flush = 1'b0; byte_ready = 1'b0; stall_cycles = 0; release_after = 0;
      model_reset();
      step();
      step();
      rst = 1'b1;
      check_val("rst_valid", {31'h0, byte_valid}, 32'd0);
      check_val("rst_byte", {24'h0, byte_out}, 32'h0);
      check_val("rst_stall", {31'h0, stall}, 32'd0);
      check_val("rst_total", total_bytes, 32'd0);
      check_val("rst_pad", {29'h0, pad_bits}, 32'd0);
      check_val("rst_done", {31'h0, done}, 32'd0);

      // Header only, downstream always ready.
      byte_ready = 1'b1;
      start_session();
      send_bits(64'h0000_0003, 32, 1'b0);
      do_flush();
      finish_session("header");

      // Partial byte 1,0,1 -> 0xA0 with five pad bits.
      start_session();
      send_bits(64'b101, 3, 1'b0);
      do_flush();
      finish_session("partial");

      // Backpressure: FIFO fills, stall holds the 33rd bit until release.
      byte_ready    = 1'b0;
      stall_cycles  = 0;
      release_after = 3;
      start_session();
      send_bits({$urandom, $urandom}, 40, 1'b0);
      check_val("bp_stall_seen", {31'h0, stall_cycles > 0}, 32'd1);
      do_flush();
      finish_session("backpressure");
      release_after = 0;

      // 8th bit coincides with flush: no extra padded byte.
      byte_ready = 1'b1;
      start_session();
      send_bits({56'h0, EOF_CHAR}, 8, 1'b1);
      finish_session("simul");

      // Sustained one bit per cycle with a ready sink never stalls.
      stall_cycles = 0;
      start_session();
      send_bits({$urandom, $urandom}, 64, 1'b0);
      check_val("thru_no_stall", stall_cycles, 32'd0);
      send_bits(64'h5, 5, 1'b1);
      finish_session("thru");

      // Abort while draining.
      byte_ready = 1'b0;
      start_session();
      send_bits(64'hC3A5, 16, 1'b0);
      do_flush();
      step();
      check_val("abort_pre_valid", {31'h0, byte_valid}, 32'd1);
      en_state = 4'd0;
      step();
      check_val("abort_valid", {31'h0, byte_valid}, 32'd0);
      check_val("abort_stall", {31'h0, stall}, 32'd0);
      check_val("abort_done", {31'h0, done}, 32'd0);
      step();
      check_val("abort_total", total_bytes, 32'd0);
      exp_q.delete();

      // Reset in the middle of packing.
      start_session();
      send_bits(64'hABC, 12, 1'b0);
      rst = 1'b0;
      step();
      check_val("mid_rst_valid", {31'h0, byte_valid}, 32'd0);
      check_val("mid_rst_byte", {24'h0, byte_out}, 32'h0);
      check_val("mid_rst_stall", {31'h0, stall}, 32'd0);
      check_val("mid_rst_total", total_bytes, 32'd0);
      check_val("mid_rst_pad", {29'h0, pad_bits}, 32'd0);
      check_val("mid_rst_done", {31'h0, done}, 32'd0);
      rst = 1'b1;
      en_state = 4'd0;
      step();
      exp_q.delete();

      // Recovery after reset.
      byte_ready = 1'b1;
      start_session();
      send_bits(64'h3F, 6, 1'b1);
      finish_session("recover");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

endmodule
